ecc_apb_master: RTL

APB initiator that drives the ECC encoder/decoder register file from a simple command/response stream. It accepts one command at a time and programs the DUT registers with four zero-wait APB writes. It then waits for operation_done and returns data_out and num_of_errors on a response handshake. It is the bus-driving end of the interface that the checker monitors, and is used by both the bench stimulus path and the system-level wrapper.

---
 rtl/ecc_apb_master.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ecc_apb_master.sv
// APB initiator that programs the ECC register file from a command stream,
// waits for operation_done and hands the result back on a response handshake.
module ecc_apb_master #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int BASE_ADDR       = 0,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_ctrl,
    input  logic [AMBA_WORD-1:0]       cmd_data,
    input  logic [1:0]                 cmd_width,
    input  logic [AMBA_WORD-1:0]       cmd_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_num_of_errors,
    output logic                       rsp_timeout
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETUP     = 3'd1;
    localparam logic [2:0] S_ACCESS    = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    logic [2:0]           state_reg;
    logic [1:0]           idx_reg;
    logic [7:0]           cnt_reg;
    logic [1:0]           ctrl_reg;
    logic [1:0]           width_reg;
    logic [AMBA_WORD-1:0] data_reg;
    logic [AMBA_WORD-1:0] noise_reg;

    logic [AMBA_ADDR_WIDTH-1:0] seq_addr [4];
    logic [AMBA_WORD-1:0]       seq_data [4];

    // Write order DATA_IN, CODEWORD_WIDTH, NOISE, CTRL: CTRL goes last as it starts the operation.
    for (genvar gi = 0; gi < 4; gi++) begin : g_seq_addr
        localparam int OFFSET = ((gi + 1) % 4) * 4;
        assign seq_addr[gi] = AMBA_ADDR_WIDTH'(BASE_ADDR + OFFSET);
    end

    assign seq_data[0] = data_reg;
    assign seq_data[1] = AMBA_WORD'(width_reg);
    assign seq_data[2] = noise_reg;
    assign seq_data[3] = AMBA_WORD'(ctrl_reg);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg         <= S_IDLE;
            idx_reg           <= 2'd0;
            cnt_reg           <= 8'd0;
            ctrl_reg          <= 2'd0;
            width_reg         <= 2'd0;
            data_reg          <= '0;
            noise_reg         <= '0;
            cmd_ready         <= 1'b1;
            PADDR             <= '0;
            PWDATA            <= '0;
            PSEL              <= 1'b0;
            PENABLE           <= 1'b0;
            PWRITE            <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_data          <= '0;
            rsp_num_of_errors <= 2'd0;
            rsp_timeout       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        ctrl_reg  <= cmd_ctrl;
                        width_reg <= cmd_width;
                        data_reg  <= cmd_data;
                        noise_reg <= cmd_noise;
                        idx_reg   <= 2'd0;
                        cmd_ready <= 1'b0;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        PWRITE    <= 1'b1;
                        PADDR     <= seq_addr[0];
                        PWDATA    <= cmd_data;
                        state_reg <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    PENABLE   <= 1'b1;
                    state_reg <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (idx_reg != 2'd3) begin
                        idx_reg   <= idx_reg + 2'd1;
                        PENABLE   <= 1'b0;
                        PADDR     <= seq_addr[idx_reg + 2'd1];
                        PWDATA    <= seq_data[idx_reg + 2'd1];
                        state_reg <= S_SETUP;
                    end else begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        PWRITE    <= 1'b0;
                        PADDR     <= '0;
                        PWDATA    <= '0;
                        cnt_reg   <= 8'd0;
                        state_reg <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    // done is checked first so it wins on the cycle the counter expires
                    if (operation_done) begin
                        rsp_valid         <= 1'b1;
                        rsp_data          <= data_out;
                        rsp_num_of_errors <= num_of_errors;
                        rsp_timeout       <= 1'b0;
                        state_reg         <= S_RESP;
                    end else if (cnt_reg == 8'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid         <= 1'b1;
                        rsp_data          <= '0;
                        rsp_num_of_errors <= 2'd0;
                        rsp_timeout       <= 1'b1;
                        state_reg         <= S_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
